id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage of the 32-bit MIPS datapath. Drives the register-file read addresses and captures the returned operands with MEM-stage forwarding applied. Holds the ID/EX pipeline register, detecting load-use hazards and inserting bubbles. Presents forwarded operands to the EX stage and keeps a saturating count of hazard stalls.

## Interface
- CTRLW, 8, width of the opaque EX/MEM/WB control bundle carried through the stage
- CNTW, 16, width of the hazard-stall counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on a rising edge where it is 1
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5  source register numbers
- id_uses_rs, id_uses_rt  in  1  instruction actually reads rs / rt
- id_wa  in  5  destination register, already resolved by the decoder
- id_regwrite, id_memread  in  1  writes a register / is a load
- id_imm  in  32  sign/zero-extended immediate
- id_ctrl  in  CTRLW  downstream control bundle
- rf_ra1, rf_ra2  out  5  register-file read addresses, combinational: id_rs, id_rt
- rf_rd1, rf_rd2  in  32  register-file read data, with reg 0 reading as 0
- mem_regwrite  in  1  MEM-stage instruction writes a register
- mem_wa  in  5  MEM-stage destination
- mem_result  in  32  MEM-stage final value, ALU result or load data
- flush  in  1  kill the instruction entering EX (branch or jump redirect)
- stall_in  in  1  downstream hold (for example, divider busy)
- id_stall  out  1  combinational; hold the PC and IF/ID register this cycle
- ex_valid, ex_regwrite, ex_memread  out  1  registered
- ex_wa, ex_rs, ex_rt  out  5  registered
- ex_ctrl  out  CTRLW  registered
- ex_imm  out  32  registered
- ex_a, ex_b  out  32  EX operands after the EX-side forward mux
- stall_cnt  out  CNTW  number of load-use bubbles inserted, saturating

## Operation
- Hazard detection (hz), combinational. hz = id_valid & ex_valid & ex_memread & (ex_wa != 0) & ((id_uses_rs & id_rs == ex_wa) | (id_uses_rt & id_rt == ex_wa)).
- Stall output. id_stall = hz | stall_in.
- ID capture forwarding.
  - a_cap = mem_result if mem_regwrite & mem_wa != 0 & mem_wa == id_rs; otherwise rf_rd1.
  - b_cap = mem_result if mem_regwrite & mem_wa != 0 & mem_wa == id_rt; otherwise rf_rd2.
  - WB-stage producers need no forward, because the register file writes on the falling edge before ID samples.
- EX-side forwarding, combinational.
  - ex_a = mem_result if ex_valid & mem_regwrite & mem_wa != 0 & mem_wa == ex_rs; otherwise the registered a.
  - ex_b follows the same rule using ex_rt.
  - This covers a producer that is exactly one instruction ahead.
- ID/EX register update, in priority order:
  - 1. reset: all registered outputs become 0, stall_cnt becomes 0.
  - 2. flush: bubble. ex_valid, ex_regwrite and ex_memread become 0; ex_ctrl becomes 0; data fields become don't-care and are driven 0.
  - 3. stall_in: hold every field unchanged.
  - 4. hz: bubble, as in item 2. stall_cnt increments unless it is all-ones.
  - 5. otherwise: load the id_* fields, a_cap and b_cap. If id_valid = 0, ex_regwrite and ex_memread are forced to 0.
- A bubble never asserts ex_regwrite or ex_memread, so it never triggers a hazard or a forward.
- A flush that coincides with hz inserts the bubble but does not increment stall_cnt.

## Timing
- Reset values: ex_valid, ex_regwrite, ex_memread, ex_wa, ex_rs, ex_rt, ex_ctrl, ex_imm and stall_cnt are all 0. ex_a and ex_b are 0 unless the EX forward condition holds, which cannot happen while ex_valid = 0.
- Latency: an ID instruction appears on the ex_* outputs one cycle after the capturing edge.
- Load-use: exactly one bubble. On the following cycle the load is in MEM and the consumer captures mem_result through the ID forward.
- While stall_in is held, the downstream pipeline is frozen, so mem_* is stable and the EX forward stays valid.
- rf_ra1 and rf_ra2 track id_rs and id_rt with no register stage.
- Reset in mid-stall: all state clears on that edge, and id_stall follows its inputs on the next cycle.

## Test plan
- Back-to-back ALU: add $3←$1+$2 with result 0x10, then sub $4←$3−$5. In the second instruction's EX cycle, ex_a = 0x10 via the EX forward (mem_wa = 3).
- Two-apart: producer $3 = 0xABCD is in MEM while the consumer is in ID. The captured ex_a = 0xABCD even though rf_rd1 returns a stale 0.
- Load-use: lw $8 then addu $9←$8+$8.
  - id_stall = 1 for exactly one cycle; a bubble enters EX; stall_cnt goes from 0 to 1.
  - The next cycle captures both operands from mem_result = 0x1234.
- $0 destination: lw $0 followed by a reader of $0 gives no stall. A producer with mem_wa = 0 gives no forward; operands read 0.
- stall_in held for 3 cycles: the ID/EX fields are unchanged and id_stall = 1 throughout. Flush asserted together with hz gives ex_valid = 0 on the next cycle and stall_cnt unchanged.
- Saturation with CNTW = 2: after 5 load-use bubbles, stall_cnt = 3. A reset pulse returns every output to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   Decode-to-execute stage of the 32-bit MIPS datapath. Drives register-file
//   read addresses, captures operands with MEM-stage forwarding, holds the
//   ID/EX pipeline register, detects load-use hazards (inserting one bubble),
//   applies a second forward on the EX side and counts hazard stalls.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : instruction currently in ID
//   rf_ra1/2, rf_rd1/2    : register-file read address / data
//   mem_regwrite/wa/result: producer currently in MEM (forward source)
//   flush                 : kill the instruction entering EX
//   stall_in              : downstream hold, freezes ID/EX
//   id_stall              : hold PC and IF/ID this cycle
//   ex_*                  : registered ID/EX fields
//   ex_a, ex_b            : EX operands after the EX-side forward mux
//   stall_cnt             : saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int CTRLW = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_wa,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic [31:0]      id_imm,
  input  logic [CTRLW-1:0] id_ctrl,
  output logic [4:0]       rf_ra1,
  output logic [4:0]       rf_ra2,
  input  logic [31:0]      rf_rd1,
  input  logic [31:0]      rf_rd2,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_wa,
  input  logic [31:0]      mem_result,
  input  logic             flush,
  input  logic             stall_in,
  output logic             id_stall,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic [4:0]       ex_wa,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [CTRLW-1:0] ex_ctrl,
  output logic [31:0]      ex_imm,
  output logic [31:0]      ex_a,
  output logic [31:0]      ex_b,
  output logic [CNTW-1:0]  stall_cnt
);

  // A MEM-stage producer supplies register ra; $0 is never forwarded.
  function automatic logic fwd_hit(input logic rw, input logic [4:0] wa,
                                   input logic [4:0] ra);
    return rw & (wa != 5'd0) & (wa == ra);
  endfunction

  logic             valid_q, valid_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q, memread_d;
  logic [4:0]       wa_q, wa_d;
  logic [4:0]       rs_q, rs_d;
  logic [4:0]       rt_q, rt_d;
  logic [CTRLW-1:0] ctrl_q, ctrl_d;
  logic [31:0]      imm_q, imm_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic             hz_s;
  logic [31:0]      a_cap_s;
  logic [31:0]      b_cap_s;

  assign rf_ra1 = id_rs;
  assign rf_ra2 = id_rt;

  // Load-use hazard, ID capture forward and EX-side forward.
  always_comb begin
    hz_s = id_valid & valid_q & memread_q & (wa_q != 5'd0) &
           ((id_uses_rs & (id_rs == wa_q)) | (id_uses_rt & (id_rt == wa_q)));
    id_stall = hz_s | stall_in;

    if (fwd_hit(mem_regwrite, mem_wa, id_rs)) begin
      a_cap_s = mem_result;
    end else begin
      a_cap_s = rf_rd1;
    end
    if (fwd_hit(mem_regwrite, mem_wa, id_rt)) begin
      b_cap_s = mem_result;
    end else begin
      b_cap_s = rf_rd2;
    end

    // Only a real instruction in EX can take the one-ahead forward.
    if (valid_q & fwd_hit(mem_regwrite, mem_wa, rs_q)) begin
      ex_a = mem_result;
    end else begin
      ex_a = a_q;
    end
    if (valid_q & fwd_hit(mem_regwrite, mem_wa, rt_q)) begin
      ex_b = mem_result;
    end else begin
      ex_b = b_q;
    end
  end

  // ID/EX next state: flush, then hold, then hazard bubble, then load.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    wa_d       = wa_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    ctrl_d     = ctrl_q;
    imm_d      = imm_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;

    if (flush || (!stall_in && hz_s)) begin
      // Bubble; a flush that coincides with a hazard is not counted.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      wa_d       = 5'd0;
      rs_d       = 5'd0;
      rt_d       = 5'd0;
      ctrl_d     = '0;
      imm_d      = 32'd0;
      a_d        = 32'd0;
      b_d        = 32'd0;
      if (!flush && (cnt_q != {CNTW{1'b1}})) begin
        cnt_d = cnt_q + CNTW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (stall_in) begin
      cnt_d = cnt_q;
    end else begin
      valid_d    = id_valid;
      regwrite_d = id_valid & id_regwrite;
      memread_d  = id_valid & id_memread;
      wa_d       = id_wa;
      rs_d       = id_rs;
      rt_d       = id_rt;
      ctrl_d     = id_ctrl;
      imm_d      = id_imm;
      a_d        = a_cap_s;
      b_d        = b_cap_s;
    end
  end

  // ID/EX pipeline register and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      wa_q       <= 5'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      ctrl_q     <= '0;
      imm_q      <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      wa_q       <= wa_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      ctrl_q     <= ctrl_d;
      imm_q      <= imm_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign ex_wa       = wa_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_imm      = imm_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage (CTRLW=8, CNTW=2). Expected ID/EX contents
//   are pushed to a queue as each instruction is driven and popped after the
//   capturing edge; combinational outputs are checked before the edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mr;
    logic [4:0]  wa;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [7:0]  ctrl;
    logic [31:0] imm;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic        id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic [31:0] id_imm;
  logic [7:0]  id_ctrl;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        mem_regwrite;
  logic [4:0]  mem_wa;
  logic [31:0] mem_result;
  logic        flush, stall_in, id_stall;
  logic        ex_valid, ex_regwrite, ex_memread;
  logic [4:0]  ex_wa, ex_rs, ex_rt;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_imm, ex_a, ex_b;
  logic [1:0]  stall_cnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last;
  logic [1:0]  ec;
  logic [31:0] ea;

  id_ex_stage #(.CTRLW(8), .CNTW(2)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wa(id_wa),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1),
    .rf_rd2(rf_rd2), .mem_regwrite(mem_regwrite), .mem_wa(mem_wa),
    .mem_result(mem_result), .flush(flush), .stall_in(stall_in),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_wa(ex_wa), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_ctrl(ex_ctrl), .ex_imm(ex_imm), .ex_a(ex_a), .ex_b(ex_b),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] wa,
                        input logic rw, input logic mr, input logic [31:0] imm,
                        input logic [7:0] ctrl, input logic [31:0] rd1,
                        input logic [31:0] rd2);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_wa = wa; id_regwrite = rw; id_memread = mr; id_imm = imm; id_ctrl = ctrl;
    rf_rd1 = rd1; rf_rd2 = rd2;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 8'd0, 32'd0, 32'd0);
  endtask

  task automatic set_mem(input logic rw, input logic [4:0] wa, input logic [31:0] res);
    mem_regwrite = rw; mem_wa = wa; mem_result = res;
  endtask

  // Expected ID/EX contents when the ID instruction is loaded.
  function automatic exp_t e_load(input logic [1:0] cnt);
    exp_t e;
    e.v = id_valid; e.rw = id_valid & id_regwrite; e.mr = id_valid & id_memread;
    e.wa = id_wa; e.rs = id_rs; e.rt = id_rt; e.ctrl = id_ctrl; e.imm = id_imm;
    e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t e_bubble(input logic [1:0] cnt);
    exp_t e;
    e = '0;
    e.cnt = cnt;
    return e;
  endfunction

  // Check combinational outputs, push expectation, clock, pop and compare.
  task automatic step(input logic e_stall, input logic [31:0] e_a,
                      input logic [31:0] e_b, input exp_t e_next);
    exp_t e;
    #1;
    chk("id_stall", 32'(id_stall), 32'(e_stall));
    chk("rf_ra1", 32'(rf_ra1), 32'(id_rs));
    chk("rf_ra2", 32'(rf_ra2), 32'(id_rt));
    chk("ex_a", ex_a, e_a);
    chk("ex_b", ex_b, e_b);
    sb.push_back(e_next);
    last = e_next;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ex_valid", 32'(ex_valid), 32'(e.v));
    chk("ex_regwrite", 32'(ex_regwrite), 32'(e.rw));
    chk("ex_memread", 32'(ex_memread), 32'(e.mr));
    chk("ex_wa", 32'(ex_wa), 32'(e.wa));
    chk("ex_rs", 32'(ex_rs), 32'(e.rs));
    chk("ex_rt", 32'(ex_rt), 32'(e.rt));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
    chk("ex_imm", ex_imm, e.imm);
    chk("stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
    idle();
    set_mem(1'b0, 5'd0, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    // Reset state
    step(1'b0, 32'd0, 32'd0, e_bubble(2'd0));
    reset = 1'b0;

    // Back-to-back ALU: add $3<-$1+$2 then sub $4<-$3-$5
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 32'd0, 8'h11, 32'h8, 32'h8);
    step(1'b0, 32'd0, 32'd0, e_load(2'd0));
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 32'd0, 8'h22, 32'h0, 32'h5);
    step(1'b0, 32'h8, 32'h8, e_load(2'd0));
    idle();
    set_mem(1'b1, 5'd3, 32'h10);
    step(1'b0, 32'h10, 32'h5, e_load(2'd0));

    // Two-apart: producer $3 in MEM, consumer in ID with stale rf data
    set_id(1'b1, 5'd3, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 32'd0, 8'h33, 32'h0, 32'h66);
    set_mem(1'b1, 5'd3, 32'hABCD);
    step(1'b0, 32'd0, 32'd0, e_load(2'd0));
    idle();
    set_mem(1'b0, 5'd0, 32'd0);
    step(1'b0, 32'hABCD, 32'h66, e_load(2'd0));

    // Load-use: lw $8 then addu $9<-$8+$8
    set_id(1'b1, 5'd29, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 32'h4, 8'h44, 32'h1000, 32'h0);
    step(1'b0, 32'd0, 32'd0, e_load(2'd0));
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'd0, 8'h55, 32'h0, 32'h0);
    step(1'b1, 32'h1000, 32'h0, e_bubble(2'd1));
    set_mem(1'b1, 5'd8, 32'h1234);
    step(1'b0, 32'd0, 32'd0, e_load(2'd1));
    idle();
    set_mem(1'b0, 5'd0, 32'd0);
    step(1'b0, 32'h1234, 32'h1234, e_load(2'd1));

    // $0 destination: no stall, no forward from mem_wa = 0
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 32'h8, 8'h66, 32'h20, 32'h0);
    step(1'b0, 32'd0, 32'd0, e_load(2'd1));
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 32'd0, 8'h77, 32'h0, 32'h0);
    set_mem(1'b1, 5'd0, 32'hDEAD);
    step(1'b0, 32'h20, 32'h0, e_load(2'd1));
    idle();
    set_mem(1'b0, 5'd0, 32'd0);
    step(1'b0, 32'd0, 32'd0, e_load(2'd1));

    // stall_in held for 3 cycles
    set_id(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 32'h55, 8'hA5, 32'h111, 32'h222);
    step(1'b0, 32'd0, 32'd0, e_load(2'd1));
    set_id(1'b1, 5'd14, 5'd15, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 32'h99, 8'h5A, 32'h333, 32'h444);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h111, 32'h222, last);
    end
    stall_in = 1'b0;
    idle();
    step(1'b0, 32'h111, 32'h222, e_load(2'd1));

    // Flush together with hazard: bubble, counter unchanged
    set_id(1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 32'd0, 8'h88, 32'h30, 32'h0);
    step(1'b0, 32'd0, 32'd0, e_load(2'd1));
    set_id(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 32'd0, 8'h99, 32'h0, 32'h0);
    flush = 1'b1;
    step(1'b1, 32'h30, 32'h0, e_bubble(2'd1));
    flush = 1'b0;
    idle();
    step(1'b0, 32'd0, 32'd0, e_load(2'd1));

    // Saturation: five more load-use bubbles on a 2-bit counter
    ec = 2'd1;
    for (int i = 0; i < 5; i++) begin
      ea = (i == 0) ? 32'd0 : 32'h1234;
      set_id(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 32'd0, 8'h0C, 32'h40, 32'h0);
      set_mem(1'b0, 5'd0, 32'd0);
      step(1'b0, ea, ea, e_load(ec));
      set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'd0, 8'h0D, 32'h0, 32'h0);
      ec = (ec == 2'd3) ? 2'd3 : ec + 2'd1;
      step(1'b1, 32'h40, 32'h0, e_bubble(ec));
      set_mem(1'b1, 5'd8, 32'h1234);
      step(1'b0, 32'd0, 32'd0, e_load(ec));
    end
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd3);

    // Reset in mid-stall clears everything; id_stall follows inputs afterwards
    set_id(1'b1, 5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 32'd0, 8'h0C, 32'h40, 32'h0);
    set_mem(1'b0, 5'd0, 32'd0);
    step(1'b0, 32'h1234, 32'h1234, e_load(2'd3));
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 32'd0, 8'h0D, 32'h0, 32'h0);
    reset = 1'b1;
    step(1'b1, 32'h40, 32'h0, e_bubble(2'd0));
    reset = 1'b0;
    step(1'b0, 32'd0, 32'd0, e_load(2'd0));
    idle();
    step(1'b0, 32'd0, 32'd0, e_load(2'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
